// File: rtl/mem_rd_arbiter.sv
// mem_rd_arbiter: round-robin owner of the single memory read channel shared
// by the icache and dcache refill paths. One cache wins each request, and it
// keeps the channel until its burst's last beat is accepted.
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   from_{i,d}cache_rd_req_*       cache read request (valid/addr), ready back
//   to_{i,d}cache_rd_rsp_*         response beats routed to the owning cache
//   from_{i,d}cache_rd_rsp_ready   cache accepts a beat
//   to_mem_rd_req_*                memory read request (valid/addr), ready in
//   from_mem_rd_rsp_*              memory response beats (valid/data/last)
//   to_mem_rd_rsp_ready            owner's ready passed back to memory
//   grant_id, busy, beat_cnt       owner, transaction in flight, beats taken
module mem_rd_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  from_icache_rd_req_valid,
  input  logic [ADDR_WIDTH-1:0] from_icache_rd_req_addr,
  output logic                  to_icache_rd_req_ready,
  output logic                  to_icache_rd_rsp_valid,
  output logic [DATA_WIDTH-1:0] to_icache_rd_rsp_data,
  output logic                  to_icache_rd_rsp_last,
  input  logic                  from_icache_rd_rsp_ready,
  input  logic                  from_dcache_rd_req_valid,
  input  logic [ADDR_WIDTH-1:0] from_dcache_rd_req_addr,
  output logic                  to_dcache_rd_req_ready,
  output logic                  to_dcache_rd_rsp_valid,
  output logic [DATA_WIDTH-1:0] to_dcache_rd_rsp_data,
  output logic                  to_dcache_rd_rsp_last,
  input  logic                  from_dcache_rd_rsp_ready,
  output logic                  to_mem_rd_req_valid,
  output logic [ADDR_WIDTH-1:0] to_mem_rd_req_addr,
  input  logic                  from_mem_rd_req_ready,
  input  logic                  from_mem_rd_rsp_valid,
  input  logic [DATA_WIDTH-1:0] from_mem_rd_rsp_data,
  input  logic                  from_mem_rd_rsp_last,
  output logic                  to_mem_rd_rsp_ready,
  output logic                  grant_id,
  output logic                  busy,
  output logic [3:0]            beat_cnt
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_REQ  = 3'b010,
    ST_RESP = 3'b100
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_owner;
  logic                  r_last_grant;
  logic [ADDR_WIDTH-1:0] r_addr_q;
  logic [CNT_W-1:0]      r_beat_cnt;

  logic w_any_req;
  logic w_winner;
  logic w_owner_rdy;
  logic w_beat;

  // On a tie the cache that did not win last time goes next.
  assign w_any_req   = from_icache_rd_req_valid | from_dcache_rd_req_valid;
  assign w_winner    = (from_icache_rd_req_valid & from_dcache_rd_req_valid)
                       ? ~r_last_grant : from_dcache_rd_req_valid;
  assign w_owner_rdy = r_owner ? from_dcache_rd_rsp_ready : from_icache_rd_rsp_ready;
  assign w_beat      = (r_state == ST_RESP) & from_mem_rd_rsp_valid & w_owner_rdy;

  assign grant_id = r_owner;
  assign busy     = (r_state != ST_IDLE);
  assign beat_cnt = r_beat_cnt;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state plus combinational request/response routing.
  always_comb begin
    w_state_nxt            = r_state;
    to_icache_rd_req_ready = 1'b0;
    to_dcache_rd_req_ready = 1'b0;
    to_icache_rd_rsp_valid = 1'b0;
    to_dcache_rd_rsp_valid = 1'b0;
    to_icache_rd_rsp_last  = 1'b0;
    to_dcache_rd_rsp_last  = 1'b0;
    to_icache_rd_rsp_data  = from_mem_rd_rsp_data;
    to_dcache_rd_rsp_data  = from_mem_rd_rsp_data;
    to_mem_rd_req_valid    = 1'b0;
    to_mem_rd_req_addr     = r_addr_q;
    to_mem_rd_rsp_ready    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_state_nxt            = ST_REQ;
          to_icache_rd_req_ready = ~w_winner;
          to_dcache_rd_req_ready = w_winner;
        end
      end
      ST_REQ: begin
        to_mem_rd_req_valid = 1'b1;
        if (from_mem_rd_req_ready) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        to_mem_rd_rsp_ready = w_owner_rdy;
        if (r_owner) begin
          to_dcache_rd_rsp_valid = from_mem_rd_rsp_valid;
          to_dcache_rd_rsp_last  = from_mem_rd_rsp_last;
        end else begin
          to_icache_rd_rsp_valid = from_mem_rd_rsp_valid;
          to_icache_rd_rsp_last  = from_mem_rd_rsp_last;
        end
        if (w_beat && from_mem_rd_rsp_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Handshakes must be dead while reset is held, not just after the next edge.
    if (rst) begin
      to_icache_rd_req_ready = 1'b0;
      to_dcache_rd_req_ready = 1'b0;
      to_icache_rd_rsp_valid = 1'b0;
      to_dcache_rd_rsp_valid = 1'b0;
      to_icache_rd_rsp_last  = 1'b0;
      to_dcache_rd_rsp_last  = 1'b0;
      to_mem_rd_req_valid    = 1'b0;
      to_mem_rd_rsp_ready    = 1'b0;
    end
  end

  // Grant bookkeeping, latched address and saturating beat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_addr_q     <= '0;
      r_beat_cnt   <= '0;
    end else if ((r_state == ST_IDLE) && w_any_req) begin
      r_addr_q     <= w_winner ? from_dcache_rd_req_addr : from_icache_rd_req_addr;
      r_owner      <= w_winner;
      r_last_grant <= w_winner;
      r_beat_cnt   <= '0;
    end else if (w_beat && (r_beat_cnt != {CNT_W{1'b1}})) begin
      r_beat_cnt   <= CNT_W'(r_beat_cnt + CNT_W'(1));
    end
  end

endmodule

// File: doc/mem_rd_arbiter.md
Name: mem_rd_arbiter

Overview:
- Shares the single memory read channel (request plus burst response) between the instruction cache and the data cache refill paths.
- Grants one cache at a time, round-robin, and holds the grant for the whole burst until the last beat is accepted.
- Sits between icache/dcache miss handling and the memory interface.

Parameters:
ADDR_WIDTH, 32, read request address width (32-byte aligned addresses pass through unchanged)
DATA_WIDTH, 32, width of one response data beat

Ports:
clk  input  1  single clock
rst  input  1  asynchronous active-high reset
from_icache_rd_req_valid  input  1  icache read request valid
from_icache_rd_req_addr  input  ADDR_WIDTH  icache request address
to_icache_rd_req_ready  output  1  request accepted from icache
to_icache_rd_rsp_valid  output  1  beat valid to icache
to_icache_rd_rsp_data  output  DATA_WIDTH  beat data to icache
to_icache_rd_rsp_last  output  1  last beat to icache
from_icache_rd_rsp_ready  input  1  icache accepts beat
from_dcache_rd_req_valid / from_dcache_rd_req_addr / to_dcache_rd_req_ready / to_dcache_rd_rsp_valid / to_dcache_rd_rsp_data / to_dcache_rd_rsp_last / from_dcache_rd_rsp_ready  same as the icache ports, for dcache
to_mem_rd_req_valid  output  1  memory read request valid
to_mem_rd_req_addr  output  ADDR_WIDTH  memory request address
from_mem_rd_req_ready  input  1  memory accepts request
from_mem_rd_rsp_valid  input  1  memory beat valid
from_mem_rd_rsp_data  input  DATA_WIDTH  memory beat data
from_mem_rd_rsp_last  input  1  memory last beat
to_mem_rd_rsp_ready  output  1  arbiter accepts beat
grant_id  output  1  current owner: 0 = icache, 1 = dcache (meaningful when busy)
busy  output  1  a transaction is in REQ or RESP
beat_cnt  output  4  beats accepted in the current burst

Behaviour:
- One clock, clk. rst is asynchronous and active-high.
- Reset (async, any state): state = IDLE; owner = 0; last_grant = 1 (icache wins the first tie); addr_q = 0; beat_cnt = 0.
- All valid/ready outputs are 0 during reset, and busy = 0.
- Reset mid-burst abandons the transaction. Memory is reset by the same rst.
- One-hot FSM with states IDLE, REQ and RESP.
- IDLE:
  - Arbitration is combinational.
  - Only icache valid: grant icache. Only dcache valid: grant dcache.
  - Both valid: grant the requester that is not last_grant.
  - The winner's req_ready = 1 in this cycle and the loser's = 0. Both req_ready = 0 in every other state.
  - On the accept edge: addr_q <= winner addr; owner <= winner; last_grant <= winner; beat_cnt <= 0; go to REQ.
- REQ:
  - to_mem_rd_req_valid = 1 and to_mem_rd_req_addr = addr_q. Both stay stable until from_mem_rd_req_ready.
  - Memory accepts in the same cycle as valid: go to RESP.
  - Request accept to mem valid is one cycle (accept at edge N, mem valid high in cycle N+1).
- RESP (pass-through, zero-cycle combinational routing):
  - Owner's rsp_valid/data/last = from_mem_rd_rsp_valid/data/last. Non-owner rsp_valid = 0 and its data is don't-care.
  - to_mem_rd_rsp_ready = owner's rsp_ready.
  - Each valid&ready beat increments beat_cnt; it saturates at 15.
  - On valid&ready&last: go to IDLE.
  - If rsp_ready is held low, the beat stalls and no state changes.
- to_mem_rd_rsp_ready = 0 in IDLE and REQ, so stray beats are not consumed.
- to_mem_rd_req_valid = 0 outside REQ.
- Completion-cycle requests: a new request present in the cycle the last beat completes is not accepted then. It is arbitrated in the following IDLE cycle, giving one bubble cycle minimum between bursts.
- A requester that is not granted keeps waiting. Its valid/addr must stay held (standard valid/ready), and the arbiter does not latch it.
- Fairness: both caches continuously requesting alternate I, D, I, D...
- Outputs: busy = (state != IDLE); grant_id = owner.

Test Plan:
- Reset, then icache valid with addr 0x00001000, dcache idle -> icache req_ready = 1 in the same cycle; next cycle mem valid = 1 with addr 0x00001000. Mem ready, then 8 beats 0xA0..0xA7 with last on the 8th -> icache receives 8 beats, last on 0xA7, beat_cnt = 8, IDLE after the last.
- Both caches valid on the first post-reset cycle (I addr 0x2000, D addr 0x3000), held continuously for 4 bursts -> grant order I, D, I, D; mem addrs 0x2000, 0x3000, 0x2000, 0x3000; exactly one bubble cycle between bursts.
- dcache burst with from_dcache_rd_rsp_ready low for 3 cycles on beat 2 -> to_mem_rd_rsp_ready low for those cycles; beat 2 delivered once; icache rsp_valid stays 0 throughout.
- from_mem_rd_req_ready held low 5 cycles in REQ -> mem valid and addr stable for 6 cycles; no rsp beat accepted before the request handshake.
- Assert rst asynchronously mid-RESP after 3 beats -> all valid/ready outputs and busy drop without waiting for a clock edge; after release an icache request at 0x4000 is granted normally with beat_cnt restarting at 0.
- icache request arrives in the same cycle as dcache's last beat -> not accepted that cycle; accepted the next cycle, with mem valid the cycle after.
